// File: rtl/memory_pkg.sv
// Shared constants and FSM state type for the wait-stated data memory.
package memory_pkg;
   localparam int DATA_MEM_SIZE_BYTES = 4096;
   localparam int DATA_MEM_SIZE_WORDS = DATA_MEM_SIZE_BYTES / 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } mem_state_t;
endpackage

// File: rtl/data_mem_array.sv
// Single-port synchronous word memory with per-byte write enables and no reset.
// The read register only changes on a read, so it holds its value across writes.
module data_mem_array #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 1024
) (
   input  logic                      clk,
   input  logic                      en,
   input  logic                      we,
   input  logic [DATA_W/8-1:0]       be,
   input  logic [$clog2(DEPTH)-1:0]  addr,
   input  logic [DATA_W-1:0]         wdata,
   output logic [DATA_W-1:0]         rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int b = 0; b < DATA_W/8; b++) begin
               if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/data_mem_ws.sv
// Data memory with WAIT_CYCLES wait states and a one-cycle ready pulse.
// Define DATA_MEM_RANGE_CHECK_EN to flag and suppress addresses >= SIZE_BYTES.
module data_mem_ws
   import memory_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int SIZE_BYTES  = DATA_MEM_SIZE_BYTES,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  mem_req_i,
   input  logic                  write_enable_i,
   input  logic [DATA_W/8-1:0]   byte_enable_i,
   input  logic [31:0]           addr_i,
   input  logic [DATA_W-1:0]     write_data_i,
   output logic [DATA_W-1:0]     read_data_o,
   output logic                  ready_o,
   output logic                  err_o
);

   localparam int BE_W  = DATA_W / 8;
   localparam int OFF   = $clog2(BE_W);
   localparam int AW    = $clog2(SIZE_BYTES);
   localparam int DEPTH = SIZE_BYTES / BE_W;

   mem_state_t        state;
   logic [3:0]        cnt;
   logic              ready_q;
   logic              rd_valid_q;

   logic              we_q;
   logic [BE_W-1:0]   be_q;
   logic [31:0]       addr_q;
   logic [DATA_W-1:0] wdata_q;

   logic              accept;
   logic              go;
   logic              live;
   logic              oor;
   logic              acc_we;
   logic [BE_W-1:0]   acc_be;
   logic [31:0]       acc_addr;
   logic [DATA_W-1:0] acc_wdata;
   logic [DATA_W-1:0] arr_rdata;
   logic              unused_addr;

   assign accept = (state == IDLE) && mem_req_i;

   // With zero wait states the access happens on the accepting edge itself,
   // so it must use the live inputs instead of the captured copies.
   assign live      = (state == IDLE);
   assign acc_we    = live ? write_enable_i : we_q;
   assign acc_be    = live ? byte_enable_i  : be_q;
   assign acc_addr  = live ? addr_i         : addr_q;
   assign acc_wdata = live ? write_data_i   : wdata_q;

   assign go = (WAIT_CYCLES == 0) ? accept : ((state == WAIT) && (cnt == 4'd1));

`ifdef DATA_MEM_RANGE_CHECK_EN
   assign oor = (acc_addr >= 32'(SIZE_BYTES));
`else
   assign oor = 1'b0;
`endif

   // Upper bits wrap away and byte-offset bits select nothing in a word memory.
   assign unused_addr = ^acc_addr;

   always_ff @(posedge clk_i) begin
      if (accept) begin
         we_q    <= write_enable_i;
         be_q    <= byte_enable_i;
         addr_q  <= addr_i;
         wdata_q <= write_data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         ready_q    <= 1'b0;
         rd_valid_q <= 1'b0;
      end else begin
         ready_q <= go;
         if (go && !acc_we) rd_valid_q <= !oor;
         case (state)
            IDLE: begin
               if (mem_req_i) begin
                  cnt   <= 4'(WAIT_CYCLES);
                  state <= (WAIT_CYCLES == 0) ? RESP : WAIT;
               end
            end
            WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) state <= RESP;
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef DATA_MEM_RANGE_CHECK_EN
   logic err_q;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) err_q <= 1'b0;
      else         err_q <= go && oor;
   end
   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

   data_mem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_array (
      .clk   (clk_i),
      .en    (go && !oor),
      .we    (acc_we),
      .be    (acc_be),
      .addr  (acc_addr[AW-1:OFF]),
      .wdata (acc_wdata),
      .rdata (arr_rdata)
   );

   // The array output is meaningless until a valid read has completed.
   assign read_data_o = rd_valid_q ? arr_rdata : '0;
   assign ready_o     = ready_q;

endmodule

// File: tb/tb_data_mem_ws.sv
// Self-checking bench for data_mem_ws: directed table, wrap/range, abort-on-reset,
// zero-wait-state throughput and randomized accesses against a byte-array model.
module tb_data_mem_ws;

   localparam int SIZE = 4096;
   localparam int W0   = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   int          checks = 0;
   int          errors = 0;

   logic        req0, we0, rdy0, err0;
   logic [3:0]  be0;
   logic [31:0] addr0, wd0, rd0;
   logic        req1, we1, rdy1, err1;
   logic [3:0]  be1;
   logic [31:0] addr1, wd1, rd1;

   logic [7:0]  ref_mem [SIZE];
   logic [31:0] last_rd;

   typedef struct {
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] exp_rd;
   } vec_t;
   vec_t vecs [11];

   always #5 clk = ~clk;

   data_mem_ws #(.DATA_W(32), .SIZE_BYTES(SIZE), .WAIT_CYCLES(W0)) dut0 (
      .clk_i(clk), .rst_ni(rst_n), .mem_req_i(req0), .write_enable_i(we0),
      .byte_enable_i(be0), .addr_i(addr0), .write_data_i(wd0),
      .read_data_o(rd0), .ready_o(rdy0), .err_o(err0));

   data_mem_ws #(.DATA_W(32), .SIZE_BYTES(SIZE), .WAIT_CYCLES(0)) dut1 (
      .clk_i(clk), .rst_ni(rst_n), .mem_req_i(req1), .write_enable_i(we1),
      .byte_enable_i(be1), .addr_i(addr1), .write_data_i(wd1),
      .read_data_o(rd1), .ready_o(rdy1), .err_o(err1));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic logic in_range(input logic [31:0] a);
`ifdef DATA_MEM_RANGE_CHECK_EN
      return a < SIZE;
`else
      return 1'b1;
`endif
   endfunction

   task automatic model_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
      int base;
      if (in_range(a)) begin
         base = int'(a % SIZE) & ~3;
         for (int k = 0; k < 4; k++) if (be[k]) ref_mem[base + k] = wd[k*8 +: 8];
      end
   endtask

   function automatic logic [31:0] model_read(input logic [31:0] a);
      int base;
      if (!in_range(a)) return 32'h0;
      base = int'(a % SIZE) & ~3;
      return {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
   endfunction

   // One access on dut0; inputs are scrambled after acceptance, and latency
   // plus single-cycle ready are checked here. Model is updated afterwards.
   task automatic do_access(input string name, input logic we, input logic [3:0] be,
                            input logic [31:0] a, input logic [31:0] wd,
                            output logic [31:0] rd, output logic er);
      int n;
      @(negedge clk);
      req0 = 1'b1; we0 = we; be0 = be; addr0 = a; wd0 = wd;
      @(posedge clk); #1;
      req0 = 1'b0; we0 = 1'($urandom); be0 = 4'($urandom);
      addr0 = $urandom; wd0 = $urandom;
      n = 1;
      while (!rdy0 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check({name, "_lat"}, n, W0 + 1);
      rd = rd0;
      er = err0;
      @(posedge clk); #1;
      check({name, "_pulse"}, {31'd0, rdy0}, 32'd0);
      if (we) model_write(a, be, wd);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] rd, exp;
      logic        er, saw, we;
      logic [3:0]  be;
      logic [31:0] a, wd;

      vecs[0]  = '{1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 32'h00000000};
      vecs[1]  = '{1'b0, 4'h3, 32'h10, 32'h0,        32'hDEADBEEF};
      vecs[2]  = '{1'b1, 4'h1, 32'h10, 32'h000000AA, 32'hDEADBEEF};
      vecs[3]  = '{1'b0, 4'hF, 32'h10, 32'h0,        32'hDEADBEAA};
      vecs[4]  = '{1'b1, 4'h0, 32'h10, 32'h55667788, 32'hDEADBEAA};
      vecs[5]  = '{1'b0, 4'h0, 32'h12, 32'h0,        32'hDEADBEAA};
      vecs[6]  = '{1'b1, 4'hF, 32'h14, 32'hCAFEF00D, 32'hDEADBEAA};
      vecs[7]  = '{1'b1, 4'h6, 32'h17, 32'h11223344, 32'hDEADBEAA};
      vecs[8]  = '{1'b0, 4'h0, 32'h14, 32'h0,        32'hCA22330D};
      vecs[9]  = '{1'b1, 4'h8, 32'h14, 32'h99000000, 32'hCA22330D};
      vecs[10] = '{1'b0, 4'hF, 32'h15, 32'h0,        32'h9922330D};

      rst_n = 1'b0;
      req0 = 1'b0; we0 = 1'b0; be0 = 4'h0; addr0 = 32'h0; wd0 = 32'h0;
      req1 = 1'b0; we1 = 1'b0; be1 = 4'h0; addr1 = 32'h0; wd1 = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready0", {31'd0, rdy0}, 32'd0);
      check("rst_err0",   {31'd0, err0}, 32'd0);
      check("rst_rdata0", rd0, 32'h0);
      check("rst_ready1", {31'd0, rdy1}, 32'd0);
      check("rst_rdata1", rd1, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("idle_ready0", {31'd0, rdy0}, 32'd0);

      for (int i = 0; i < 11; i++) begin
         do_access($sformatf("vec%0d", i), vecs[i].we, vecs[i].be, vecs[i].addr,
                   vecs[i].wd, rd, er);
         check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
         check($sformatf("vec%0d_err", i), {31'd0, er}, 32'd0);
      end
      last_rd = 32'h9922330D;

      // Address 0x1000 is one past the end of a 4 KiB memory.
      do_access("wrap_w0", 1'b1, 4'hF, 32'h0, 32'h01020304, rd, er);
      check("wrap_w0_err", {31'd0, er}, 32'd0);
      do_access("wrap_wX", 1'b1, 4'hF, 32'h1000, 32'hA5A5A5A5, rd, er);
      check("wrap_wX_rd", rd, last_rd);
`ifdef DATA_MEM_RANGE_CHECK_EN
      check("wrap_wX_err", {31'd0, er}, 32'd1);
      do_access("wrap_r0", 1'b0, 4'hF, 32'h0, 32'h0, rd, er);
      check("wrap_r0_rd", rd, 32'h01020304);
      check("wrap_r0_err", {31'd0, er}, 32'd0);
      do_access("wrap_rX", 1'b0, 4'hF, 32'h1000, 32'h0, rd, er);
      check("wrap_rX_rd", rd, 32'h0);
      check("wrap_rX_err", {31'd0, er}, 32'd1);
`else
      check("wrap_wX_err", {31'd0, er}, 32'd0);
      do_access("wrap_r0", 1'b0, 4'hF, 32'h0, 32'h0, rd, er);
      check("wrap_r0_rd", rd, 32'hA5A5A5A5);
      check("wrap_r0_err", {31'd0, er}, 32'd0);
      do_access("wrap_rX", 1'b0, 4'hF, 32'h1000, 32'h0, rd, er);
      check("wrap_rX_rd", rd, 32'hA5A5A5A5);
      check("wrap_rX_err", {31'd0, er}, 32'd0);
`endif

      // Reset in the middle of a write's wait states must abort it.
      do_access("abort_pre", 1'b1, 4'hF, 32'h30, 32'h0BADF00D, rd, er);
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b1; be0 = 4'hF; addr0 = 32'h30; wd0 = 32'h12345678;
      @(posedge clk); #1;
      req0 = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #2;
      check("abort_rst_ready", {31'd0, rdy0}, 32'd0);
      check("abort_rst_rdata", rd0, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      saw = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         saw = saw | rdy0;
      end
      check("abort_no_ready", {31'd0, saw}, 32'd0);
      do_access("abort_rd", 1'b0, 4'hF, 32'h30, 32'h0, rd, er);
      check("abort_rd_val", rd, 32'h0BADF00D);
      last_rd = rd;

      // Zero wait states: ready the cycle after accept, back-to-back every 2 cycles.
      @(negedge clk);
      req1 = 1'b1; we1 = 1'b1; be1 = 4'hF; addr1 = 32'h20; wd1 = 32'h77665544;
      @(posedge clk); #1;
      check("w0_wr_ready", {31'd0, rdy1}, 32'd1);
      req1 = 1'b0; we1 = 1'b0; wd1 = 32'h0;
      @(posedge clk); #1;
      check("w0_wr_pulse", {31'd0, rdy1}, 32'd0);
      @(negedge clk);
      req1 = 1'b1; we1 = 1'b0; be1 = 4'h0; addr1 = 32'h20;
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk); #1;
         check($sformatf("w0_rep%0d_ready", i), {31'd0, rdy1}, 32'(i % 2));
         if (i % 2 == 1) begin
            check($sformatf("w0_rep%0d_rd", i), rd1, 32'h77665544);
            check($sformatf("w0_rep%0d_err", i), {31'd0, err1}, 32'd0);
         end
      end
      req1 = 1'b0;

      // Randomized traffic over the first 16 words.
      for (int w = 0; w < 16; w++) begin
         do_access($sformatf("init%0d", w), 1'b1, 4'hF, 32'(w * 4), $urandom, rd, er);
         check($sformatf("init%0d_hold", w), rd, last_rd);
      end
      for (int i = 0; i < 60; i++) begin
         we = 1'($urandom);
         be = 4'($urandom);
         a  = 32'($urandom_range(0, 63));
         wd = $urandom;
         exp = we ? last_rd : model_read(a);
         do_access($sformatf("rnd%0d", i), we, be, a, wd, rd, er);
         check($sformatf("rnd%0d_rd", i), rd, exp);
         check($sformatf("rnd%0d_err", i), {31'd0, er}, 32'd0);
         if (!we) last_rd = exp;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/data_mem_ws.md
DATA_MEM_WS -- requirements
Module: data_mem_ws

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, data word width in bits (multiple of 8).
REQ-002 The block SHALL have parameter SIZE_BYTES, default memory_pkg::DATA_MEM_SIZE_BYTES, capacity in bytes (power of 2, >= DATA_W/8).
REQ-003 The block SHALL have parameter WAIT_CYCLES, default 2, extra wait states per access (0..15).
REQ-004 The block SHALL use one clock and asynchronous active-low reset; ports clk_i, rst_ni.
REQ-005 Ports SHALL be:
- clk_i  in  1  clock, all state on rising edge.
- rst_ni  in  1  async reset, active low.
- mem_req_i  in  1  access request.
- write_enable_i  in  1  1 = write, 0 = read.
- byte_enable_i  in  DATA_W/8  per-byte write mask.
- addr_i  in  32  byte address.
- write_data_i  in  DATA_W  write data.
- read_data_o  out  DATA_W  read data.
- ready_o  out  1  one-cycle completion pulse.
- err_o  out  1  out-of-range flag, valid with ready_o.

Function
REQ-006 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-007 In IDLE, mem_req_i=1 SHALL capture addr_i, write_enable_i, byte_enable_i and write_data_i, load the wait counter with WAIT_CYCLES, and go to WAIT, or to RESP if WAIT_CYCLES=0.
REQ-008 In WAIT, the counter SHALL decrement each cycle; on the cycle it is 0 the access SHALL be performed and the FSM SHALL go to RESP.
REQ-009 In RESP, ready_o SHALL be 1 for exactly one cycle; the FSM SHALL then return to IDLE, and mem_req_i SHALL be ignored in RESP.
REQ-010 ready_o SHALL rise WAIT_CYCLES+1 cycles after the accepting edge; minimum request spacing SHALL be WAIT_CYCLES+2 cycles.
REQ-011 Inputs changing after acceptance SHALL NOT affect the captured access.
REQ-012 Word index SHALL be addr_i[$clog2(SIZE_BYTES)-1:$clog2(DATA_W/8)]; the low byte-offset bits SHALL be ignored.
REQ-013 A write SHALL update only the bytes whose byte_enable bit is 1; the other bytes SHALL keep their old values.
REQ-014 A write with an all-zero byte_enable SHALL leave memory unchanged and still produce ready_o.
REQ-015 A read SHALL return the full word, ignoring byte_enable.
REQ-016 read_data_o SHALL be valid while ready_o=1 and SHALL hold its value until the next read completes; writes SHALL NOT change it.
REQ-017 ready_o=0 SHALL hold in IDLE and WAIT.

Reset
REQ-018 Reset SHALL set the FSM to IDLE, the counter to 0, and ready_o, err_o and read_data_o to 0.
REQ-019 Reset SHALL NOT clear the memory array contents.
REQ-020 Reset during WAIT SHALL abort the access: a pending write SHALL NOT be performed and no ready_o SHALL follow.

Configuration
REQ-021 With DATA_MEM_RANGE_CHECK_EN defined, an access with addr_i >= SIZE_BYTES SHALL be suppressed (no write, read_data_o=0), take the normal latency, and assert err_o together with ready_o.
REQ-022 Without DATA_MEM_RANGE_CHECK_EN, the address SHALL wrap modulo SIZE_BYTES and err_o SHALL be tied to 0.

Structure
REQ-023 memory_pkg SHALL hold DATA_MEM_SIZE_BYTES, DATA_MEM_SIZE_WORDS and the FSM state enum typedef.
REQ-024 Storage SHALL be the sub-module data_mem_array: synchronous, byte-enabled, single-port, no reset.

Verification
REQ-025 Write 0xDEADBEEF to 0x10 with BE=1111, then read 0x10 -> ready_o 3 cycles after each accept; read_data_o=0xDEADBEEF.
REQ-026 Write 0x000000AA to 0x10 with BE=0001 over 0xDEADBEEF, then read -> 0xDEADBEAA; BE=0000 write -> word unchanged.
REQ-027 WAIT_CYCLES=0, read at 0x20 -> ready_o on the cycle after accept; repeated requests -> ready_o every 2 cycles.
REQ-028 Assert rst_ni low during WAIT of a write of 0x12345678 to 0x30 -> no ready_o; a later read of 0x30 returns the old value.
REQ-029 With the macro defined, SIZE_BYTES=4096, write to 0x1000 -> err_o=1 with ready_o and word 0 unchanged; without the macro -> word 0 is written and err_o=0.
REQ-030 Change addr_i and write_data_i during WAIT -> the originally captured address and data are used.
